// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider for MIPS DIV/DIVU, one quotient bit per clock
module seq_divider #(
  parameter int WWidth = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              signed_op,
  input  logic [WWidth-1:0] dividend,
  input  logic [WWidth-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [WWidth-1:0] quotient,
  output logic [WWidth-1:0] remainder,
  output logic              div_by_zero
);
  localparam int CW = $clog2(WWidth + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state, state_n;
  logic [WWidth-1:0] q, r, d, num, mag_a, mag_b;
  logic [WWidth:0] rs;
  logic [WWidth+1:0] t;
  logic [CW-1:0] count;
  logic sgn, neg_a, neg_b;
  always_comb begin
    mag_a = signed_op && dividend[WWidth-1] ? -dividend : dividend;
    mag_b = signed_op && divisor[WWidth-1] ? -divisor : divisor;
    rs = {r, q[WWidth-1]};
    t = {1'b0, rs} - {2'b0, d};
    state_n = state == IDLE ? (start ? RUN : IDLE)
            : state == RUN ? (count == CW'(1) ? FIX : RUN)
            : state == FIX ? DONE : IDLE;
    busy = state == RUN || state == FIX;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      q <= '0;
      r <= '0;
      d <= '0;
      num <= '0;
      count <= '0;
      sgn <= 1'b0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        sgn <= signed_op;
        neg_a <= dividend[WWidth-1];
        neg_b <= divisor[WWidth-1];
        num <= dividend;
        q <= mag_a;
        d <= mag_b;
        r <= '0;
        count <= CW'(WWidth);
      end
      if (state == RUN) begin
        q <= {q[WWidth-2:0], ~t[WWidth+1]};
        r <= t[WWidth+1] ? rs[WWidth-1:0] : t[WWidth-1:0];
        count <= count - 1'b1;
      end
      if (state == FIX) begin
        quotient <= d == '0 ? '1 : (sgn && (neg_a ^ neg_b) ? -q : q);
        remainder <= d == '0 ? num : (sgn && neg_a ? -r : r);
        div_by_zero <= d == '0;
      end
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table-driven checks of seq_divider plus ignored-start and mid-op reset sequences
module tb_seq_divider;
  logic clk = 1'b0;
  logic reset, start, signed_op, busy, done, div_by_zero;
  logic [31:0] dividend, divisor, quotient, remainder;
  int checks = 0, errors = 0;
  logic [31:0] prev_q = '0;
  typedef struct {
    logic sop;
    logic [31:0] a, b, eq, er;
    logic ez;
  } vec_t;
  vec_t vecs[10];
  seq_divider #(.WWidth(32)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run_op(input logic sop, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic ez, input int inj);
    int n;
    logic bad;
    bad = 1'b0;
    start = 1'b1;
    signed_op = sop;
    dividend = a;
    divisor = b;
    @(negedge clk);
    start = 1'b0;
    dividend = ~a;
    divisor = ~b;
    n = 1;
    while (!done && n < 60) begin
      if (!busy) bad = 1'b1;
      if (n == 20) chk("hold_q", quotient, prev_q);
      start = n == inj;
      if (n == inj) begin
        dividend = 32'd50;
        divisor = 32'd5;
        signed_op = ~sop;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("busy_run", 32'(bad), 32'd0);
    chk("latency", 32'(n), 32'd34);
    chk("busy_in_done", 32'(busy), 32'd0);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", 32'(div_by_zero), 32'(ez));
    prev_q = eq;
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
  endtask
  initial begin
    int cnt;
    vecs[0] = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
    vecs[1] = '{1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    vecs[2] = '{1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0};
    vecs[3] = '{1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0};
    vecs[4] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0};
    vecs[5] = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0};
    vecs[6] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 1'b0};
    vecs[7] = '{1'b1, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b1};
    vecs[8] = '{1'b1, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0};
    vecs[9] = '{1'b0, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0};
    reset = 1'b1;
    start = 1'b0;
    signed_op = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_dz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++)
      run_op(vecs[i].sop, vecs[i].a, vecs[i].b, vecs[i].eq, vecs[i].er, vecs[i].ez, 0);
    run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 10);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("extra_done", 32'(cnt), 32'd0);
    chk("kept_q", quotient, 32'd14);
    start = 1'b1;
    signed_op = 1'b0;
    dividend = 32'd100;
    divisor = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_q", quotient, 32'd0);
    chk("mid_rst_r", remainder, 32'd0);
    chk("mid_rst_dz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("rst_no_done", 32'(cnt), 32'd0);
    prev_q = '0;
    run_op(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
